// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor / ripple-carry adder.
// Consumes DIGIT operand bits per clock, LSB first, with a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig;
  logic             cy;
  logic             cin_top;

  // Operands shift right each cycle, so bits [DIGIT-1:0] are the live digit.
  always_comb begin
    cy      = c_q;
    cin_top = c_q;
    dig     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      cin_top = cy;
      dig[i]  = a_q[i] ^ b_q[i] ^ cy;
      if (mode_q) begin
        cy = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & cy);
      end else begin
        cy = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & cy);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;
    res_d   = res_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          c_d     = bin;
        end
      end
      (state_q == S_RUN): begin
        a_d = a_q >> DIGIT;
        b_d = b_q >> DIGIT;
        c_d = cy;
        res_d[int'(cnt_q)*DIGIT +: DIGIT] = dig;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          bout_d  = cy;
          ovf_d   = cin_top ^ cy;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign bout   = bout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a 4-bit/1-digit and an 8-bit/2-digit instance
// share control inputs; an arithmetic model predicts timing and results.
module tb_serial_subtractor;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic bin = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;

  logic busy4, done4, bout4, ovf4;
  logic [3:0] res4;
  logic busy8, done8, bout8, ovf8;
  logic [7:0] res8;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a4), .b(b4), .bin(bin),
    .busy(busy4), .done(done4), .result(res4),
    .bout(bout4), .ovf(ovf4)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a(a8), .b(b8), .bin(bin),
    .busy(busy8), .done(done8), .result(res8),
    .bout(bout8), .ovf(ovf8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit         le4 = 0;
  bit         le8 = 0;
  logic [5:0] l4  = '0;
  logic [9:0] l8  = '0;
  bit         hold_chk = 0;

  // {ovf, carry/borrow out, result} from plain signed/unsigned arithmetic
  function automatic logic [9:0] ref_op(input int w, input logic [7:0] x,
                                        input logic [7:0] y, input logic bi,
                                        input logic m);
    longint md, ux, uy, sx, sy, bl, r, s;
    logic co, ov;
    md = longint'(1) << w;
    ux = longint'(x);
    uy = longint'(y);
    bl = bi ? longint'(1) : longint'(0);
    sx = x[w-1] ? ux - md : ux;
    sy = y[w-1] ? uy - md : uy;
    if (m) begin
      r  = ux + uy + bl;
      co = (r >= md);
      s  = sx + sy + bl;
    end else begin
      r  = ux - uy - bl;
      co = (ux < uy + bl);
      s  = sx - sy - bl;
    end
    r  = ((r % md) + md) % md;
    ov = (s > md / 2 - 1) || (s < -(md / 2));
    return {ov, co, r[7:0]};
  endfunction

  // Model: k counts edges since the accepting edge, 0 means idle.
  int         k = 0;
  logic [9:0] e4 = '0, e8 = '0, p4 = '0, p8 = '0;
  bit         m_le4 = 0, m_le8 = 0;
  logic [5:0] m_l4 = '0;
  logic [9:0] m_l8 = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; e4 = '0; e8 = '0; m_le4 = 0; m_le8 = 0;
    end else if (k == 0) begin
      if (start) begin
        k = 1;
        p4 = ref_op(4, {4'b0, a4}, {4'b0, b4}, bin, mode);
        p8 = ref_op(8, a8, b8, bin, mode);
        m_le4 = le4; m_l4 = l4;
        m_le8 = le8; m_l8 = l8;
      end
    end else if (k == N + 1) begin
      k = 0;
    end else begin
      k = k + 1;
      if (k == N + 1) begin
        e4 = p4; e8 = p8;
      end
    end
  end

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  int prev = -1;

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("busy4", 10'(busy4), 10'(k != 0));
    chk("busy8", 10'(busy8), 10'(k != 0));
    chk("done4", 10'(done4), 10'(k == N + 1));
    chk("done8", 10'(done8), 10'(k == N + 1));
    if (k == 0 || k == N + 1) begin
      chk("out4", 10'({ovf4, bout4, res4}), 10'({e4[9:8], e4[3:0]}));
      chk("out8", {ovf8, bout8, res8}, e8);
    end
    if (k == N + 1 && m_le4) begin
      chk("lit4_dut", 10'({ovf4, bout4, res4}), 10'(m_l4));
      chk("lit4_model", 10'({e4[9:8], e4[3:0]}), 10'(m_l4));
    end
    if (k == N + 1 && m_le8) begin
      chk("lit8_dut", {ovf8, bout8, res8}, m_l8);
      chk("lit8_model", e8, m_l8);
    end
    if (!hold_chk) begin
      prev = -1;
    end else if (done4) begin
      if (prev >= 0) chk("done_gap", 10'(cyc - prev), 10'(N + 2));
      prev = cyc;
    end
  end

  task automatic op(input logic [3:0] xa, input logic [3:0] xb,
                    input logic [7:0] ya, input logic [7:0] yb,
                    input logic m, input logic bi,
                    input bit en4, input logic [5:0] x4,
                    input bit en8, input logic [9:0] x8,
                    input bit scr, input bit pls);
    @(posedge clk); #2;
    a4 = xa; b4 = xb; a8 = ya; b8 = yb; mode = m; bin = bi;
    le4 = en4; l4 = x4; le8 = en8; l8 = x8;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (scr) begin
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
        mode = 1'($urandom); bin = 1'($urandom);
      end
      start = pls && (i == 1);
      @(posedge clk); #2;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    op(4'b0111, 4'b0110, 8'h00, 8'h01, 0, 0, 1, 6'b000001, 1, 10'h1FF, 1, 1);
    op(4'b0100, 4'b0011, 8'h37, 8'h12, 0, 0, 1, 6'b000001, 0, '0, 0, 0);
    op(4'b0011, 4'b0110, 8'h80, 8'h01, 0, 0, 1, 6'b011101, 0, '0, 0, 1);
    op(4'b0111, 4'b1000, 8'h7F, 8'hFF, 0, 0, 1, 6'b111111, 0, '0, 0, 0);
    op(4'b1101, 4'b0101, 8'hFF, 8'hFF, 0, 0, 1, 6'b001000, 0, '0, 1, 0);
    op(4'b1100, 4'b1011, 8'h00, 8'h00, 0, 1, 1, 6'b000000, 0, '0, 0, 0);
    op(4'b0111, 4'b0001, 8'h7F, 8'h01, 1, 0, 1, 6'b101000, 0, '0, 0, 0);
    op(4'b1111, 4'b0001, 8'hFF, 8'h01, 1, 0, 1, 6'b010000, 0, '0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      op(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
         1'($urandom), 1'($urandom), 0, '0, 0, '0, 1, (t % 4) == 0);
    end

    // abort an operation with reset two edges after it was accepted
    @(posedge clk); #2;
    a4 = 4'b1010; b4 = 4'b0011; a8 = 8'hC3; b8 = 8'h3C; mode = 0; bin = 0;
    le4 = 0; le8 = 0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    op(4'b0100, 4'b0011, 8'h00, 8'h01, 0, 0, 1, 6'b000001, 1, 10'h1FF, 0, 0);

    // start held high across three operations
    @(posedge clk); #2;
    hold_chk = 1;
    a4 = 4'b0111; b4 = 4'b0110; a8 = 8'h5A; b8 = 8'hA5; mode = 0; bin = 0;
    le4 = 1; l4 = 6'b000001; le8 = 0;
    start = 1'b1;
    repeat (14) @(posedge clk);
    #2 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 hold_chk = 0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
